// File: rtl/fmap_pkg.sv
// Shared types and defaults for the feature-map stream writer.
package fmap_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fsm_state_e;
endpackage

// File: rtl/fmap_sync_fifo.sv
// Synchronous FIFO with registered head; a push on full is accepted only
// when a pop frees the slot in the same cycle.
module fmap_sync_fifo
  import fmap_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CW-1:0]     count_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/fmap_stream_writer.sv
// Activation stream sink: buffers words in a skid FIFO and writes them to
// FM SRAM at Base_Addr+n. Optional Zero_Cnt output under `ZERO_COUNT_EN.
module fmap_stream_writer
  import fmap_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int AFULL_LVL  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Base_Addr,
  input  logic [ADDR_W-1:0] Num_Words,
  input  logic [DATA_W-1:0] Data_In,
  input  logic              Valid_In,
  output logic              Ready_Out,
  output logic              Mem_Wr_En,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Wr_Data,
  input  logic              Mem_Wr_Ack,
  output logic              Busy,
  output logic              Done,
  output logic              Overflow
`ifdef ZERO_COUNT_EN
  ,
  output logic [ADDR_W-1:0] Zero_Cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

  fsm_state_e        state_q, state_d;
  logic [ADDR_W-1:0] base_q, num_q, rx_q, wr_q, pushed_q;
  logic              ovf_q;
  logic              take, push_ok, pop, start_ok;
  logic              f_full, f_empty;
  logic [CW-1:0]     f_count;
  logic [DATA_W-1:0] f_head;

  fmap_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (take),
    .pop_i   (pop),
    .din_i   (Data_In),
    .dout_o  (f_head),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_count)
  );

  // Every qualified word consumes an rx slot, even when the FIFO drops it.
  assign take     = (state_q == ST_RUN) && Valid_In && (rx_q < num_q);
  assign pop      = Mem_Wr_Ack && !f_empty;
  assign push_ok  = take && (!f_full || pop);
  assign start_ok = (state_q == ST_IDLE) && Start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (Start) state_d = (Num_Words == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (rx_q == num_q) state_d = ST_DRAIN;
      ST_DRAIN: if (wr_q == pushed_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      num_q    <= '0;
      rx_q     <= '0;
      wr_q     <= '0;
      pushed_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        base_q   <= Base_Addr;
        num_q    <= Num_Words;
        rx_q     <= '0;
        wr_q     <= '0;
        pushed_q <= '0;
        ovf_q    <= 1'b0;
      end else begin
        if (take)             rx_q     <= rx_q + ADDR_W'(1);
        if (push_ok)          pushed_q <= pushed_q + ADDR_W'(1);
        if (take && !push_ok) ovf_q    <= 1'b1;
        if (pop)              wr_q     <= wr_q + ADDR_W'(1);
      end
    end
  end

`ifdef ZERO_COUNT_EN
  logic [ADDR_W-1:0] zero_q;
  always_ff @(posedge clk) begin
    if (rst || start_ok)            zero_q <= '0;
    else if (pop && f_head == '0)   zero_q <= zero_q + ADDR_W'(1);
  end
  assign Zero_Cnt = zero_q;
`endif

  // Address/data forced to zero when idle so stale FIFO contents never show.
  assign Mem_Wr_En   = !f_empty;
  assign Mem_Addr    = f_empty ? '0 : base_q + wr_q;
  assign Mem_Wr_Data = f_empty ? '0 : f_head;
  assign Ready_Out   = (state_q == ST_RUN) && (f_count < AFULL_C);
  assign Busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign Done        = (state_q == ST_DONE);
  assign Overflow    = ovf_q;
endmodule
